adc_sar_fsm: RTL

//  Successive-approximation control FSM; the producer side of the oversampling filter's sample interface.
//  - Runs sample phase, then binary search on capacitive DAC code using comparator.
//  - Presents each finished conversion as data_out (RESOLUTION bits) plus data_valid_strobe_out.
//  - data_valid_strobe_out is a glitch-free registered pulse; downstream may use it as a clock edge.

---
 rtl/adc_sar_fsm_if.sv | 34 +++
 rtl/adc_sar_fsm.sv | 120 ++++++++++++
 2 files changed

// File: rtl/adc_sar_fsm_if.sv
// Sample interface of the SAR converter: enable/comparator inputs toward the FSM,
// DAC trial code, conversion result and strobe out of it.
// master = SAR FSM side, slave = analog front end / downstream consumer side.
interface adc_sar_fsm_if #(
    parameter int RESOLUTION = 12
);
    logic                  enable_in;
    logic                  comparator_in;
    logic                  sample_out;
    logic [RESOLUTION-1:0] dac_code_out;
    logic [RESOLUTION-1:0] data_out;
    logic                  data_valid_strobe_out;
    logic                  busy_out;

    modport master (
        input  enable_in,
        input  comparator_in,
        output sample_out,
        output dac_code_out,
        output data_out,
        output data_valid_strobe_out,
        output busy_out
    );

    modport slave (
        output enable_in,
        output comparator_in,
        input  sample_out,
        input  dac_code_out,
        input  data_out,
        input  data_valid_strobe_out,
        input  busy_out
    );
endinterface

// File: rtl/adc_sar_fsm.sv
// Successive-approximation control FSM: sample phase, then MSB-first binary search
// on the capacitive DAC code, then a one-cycle DONE that launches a registered strobe.
// Optional macro ADC_SAR_CMP_SYNC_EN: comparator goes through a capture flop and
// each bit takes two cycles (SET drives the trial code, EVAL decides from cmp_q).
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for enable_in; switch open, DAC code 0
// SAMPLE  | sampling switch closed for SAMPLE_CYCLES cycles
// CONVERT | one bit decision per step, MSB first
// DONE    | result published on data_out; strobe rises on exit
module adc_sar_fsm #(
    parameter int RESOLUTION    = 12,
    parameter int SAMPLE_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    adc_sar_fsm_if.master sar
);
    typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE} state_t;

    localparam int IDX_W = $clog2(RESOLUTION);
    localparam int CNT_W = $clog2(SAMPLE_CYCLES + 1);
    localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(RESOLUTION - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SAMPLE_CYCLES - 1);

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      sample_cnt;
    logic [IDX_W-1:0]      bit_idx;
    logic [RESOLUTION-1:0] result;
    logic [RESOLUTION-1:0] data_q;
    logic                  strobe_q;
    logic [RESOLUTION-1:0] trial_bit;
    logic [RESOLUTION-1:0] decided;
    logic                  cmp_bit;
    logic                  bit_step;

`ifdef ADC_SAR_CMP_SYNC_EN
    logic cmp_q;
    logic eval_phase;

    // Capture comparator and alternate SET/EVAL phases while converting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_q      <= 1'b0;
            eval_phase <= 1'b0;
        end else begin
            cmp_q      <= sar.comparator_in;
            eval_phase <= (state == CONVERT) ? ~eval_phase : 1'b0;
        end
    end

    assign cmp_bit  = cmp_q;
    assign bit_step = eval_phase;
`else
    assign cmp_bit  = sar.comparator_in;
    assign bit_step = 1'b1;
`endif

    assign trial_bit = {{(RESOLUTION-1){1'b0}}, 1'b1} << bit_idx;
    assign decided   = cmp_bit ? (result | trial_bit) : (result & ~trial_bit);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sar.enable_in) state_nxt = SAMPLE;
            SAMPLE:  if (sample_cnt == '0) state_nxt = CONVERT;
            CONVERT: if (bit_step && (bit_idx == '0)) state_nxt = DONE;
            DONE:    state_nxt = sar.enable_in ? SAMPLE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Sample timer, successive-approximation register, result and strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt <= CNT_LOAD;
            bit_idx    <= IDX_MSB;
            result     <= '0;
            data_q     <= '0;
            strobe_q   <= 1'b0;
        end else begin
            strobe_q <= (state == DONE);
            if (state != SAMPLE)
                sample_cnt <= CNT_LOAD;
            else if (sample_cnt != '0)
                sample_cnt <= sample_cnt - CNT_W'(1);
            if ((state == SAMPLE) && (sample_cnt == '0)) begin
                result  <= '0;
                bit_idx <= IDX_MSB;
            end else if ((state == CONVERT) && bit_step) begin
                result <= decided;
                if (bit_idx == '0) data_q  <= decided;
                else               bit_idx <= bit_idx - IDX_W'(1);
            end
        end
    end

    // DAC code: trial during conversion, final result held through DONE.
    always_comb begin
        sar.dac_code_out = '0;
        case (state)
            CONVERT: sar.dac_code_out = result | trial_bit;
            DONE:    sar.dac_code_out = result;
            default: sar.dac_code_out = '0;
        endcase
    end

    assign sar.sample_out            = (state == SAMPLE);
    assign sar.busy_out              = (state != IDLE);
    assign sar.data_out              = data_q;
    assign sar.data_valid_strobe_out = strobe_q;
endmodule
